// File: rtl/instr_encode.sv
// Packs opcode/param fields into 16-bit words, buffers them in a small FIFO and
// numbers each delivered word; a HALT_OP word closes the stream until restart.
module instr_encode #(
    parameter int         DEPTH   = 4,
    parameter int         ADDR_W  = 8,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic                     IE_clock,
    input  logic                     IE_reset,
    input  logic                     in_valid,
    input  logic [3:0]               in_opcode,
    input  logic [5:0]               in_param1,
    input  logic [5:0]               in_param2,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_instruction,
    output logic [ADDR_W-1:0]        out_addr,
    input  logic                     restart,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     done,
    output logic                     wrap_flag
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [15:0]         mem_r [DEPTH];
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [PW:0]         count_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                wrap_r;
    logic                push_s;
    logic                pop_s;
    logic                restart_s;

    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    // Restart only counts once the halted stream has fully drained.
    assign restart_s = (state_r == HALTED) && restart && (count_r == '0);

    assign out_instruction = mem_r[rd_ptr_r];
    assign out_addr        = addr_r;
    assign count           = count_r;
    assign wrap_flag       = wrap_r;

    // State register.
    always_ff @(posedge IE_clock or posedge IE_reset) begin
        if (IE_reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: halt on accepting HALT_OP, resume on a qualified restart.
    always_comb begin
        state_s = state_r;
        case (state_r)
            RUN: begin
                if (push_s && (in_opcode == HALT_OP)) begin
                    state_s = HALTED;
                end else begin
                    state_s = RUN;
                end
            end
            HALTED: begin
                if (restart_s) begin
                    state_s = RUN;
                end else begin
                    state_s = HALTED;
                end
            end
            default: state_s = RUN;
        endcase
    end

    // Output decode from state and occupancy.
    always_comb begin
        in_ready  = 1'b0;
        done      = 1'b0;
        out_valid = (count_r != '0);
        case (state_r)
            RUN: begin
                in_ready = (count_r < DEPTH_C);
                done     = 1'b0;
            end
            HALTED: begin
                in_ready = 1'b0;
                done     = (count_r == '0);
            end
            default: begin
                in_ready = 1'b0;
                done     = 1'b0;
            end
        endcase
    end

    // Word buffer, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge IE_clock or posedge IE_reset) begin
        if (IE_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 16'h0000;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {in_opcode, in_param1, in_param2};
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Program address of the head word and its sticky wrap indicator.
    always_ff @(posedge IE_clock or posedge IE_reset) begin
        if (IE_reset) begin
            addr_r <= '0;
            wrap_r <= 1'b0;
        end else if (restart_s) begin
            addr_r <= '0;
            wrap_r <= 1'b0;
        end else if (pop_s) begin
            addr_r <= addr_r + ADDR_W'(1);
            if (addr_r == {ADDR_W{1'b1}}) begin
                wrap_r <= 1'b1;
            end else begin
                wrap_r <= wrap_r;
            end
        end else begin
            addr_r <= addr_r;
            wrap_r <= wrap_r;
        end
    end

endmodule

// File: tb/tb_instr_encode.sv
// Directed bench for instr_encode: a queue-based model checked every cycle on
// two instances (8-bit and 2-bit address counters), plus hand-computed literals.
module tb_instr_encode;

    localparam int         DEPTH   = 4;
    localparam logic [3:0] HALT_OP = 4'hF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_opcode = 4'h0;
    logic [5:0]  in_param1 = 6'h00;
    logic [5:0]  in_param2 = 6'h00;
    logic        out_ready = 1'b0;
    logic        restart = 1'b0;

    logic        in_ready, out_valid, done, wrap_flag;
    logic [15:0] out_instruction;
    logic [7:0]  out_addr;
    logic [2:0]  count;

    logic        in_ready2, out_valid2, done2, wrap_flag2;
    logic [15:0] out_instruction2;
    logic [1:0]  out_addr2;
    logic [2:0]  count2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    instr_encode #(.DEPTH(DEPTH), .ADDR_W(8), .HALT_OP(HALT_OP)) dut (
        .IE_clock(clk), .IE_reset(rst), .in_valid(in_valid), .in_opcode(in_opcode),
        .in_param1(in_param1), .in_param2(in_param2), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
        .out_addr(out_addr), .restart(restart), .count(count), .done(done),
        .wrap_flag(wrap_flag)
    );

    instr_encode #(.DEPTH(DEPTH), .ADDR_W(2), .HALT_OP(HALT_OP)) dut2 (
        .IE_clock(clk), .IE_reset(rst), .in_valid(in_valid), .in_opcode(in_opcode),
        .in_param1(in_param1), .in_param2(in_param2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instruction(out_instruction2),
        .out_addr(out_addr2), .restart(restart), .count(count2), .done(done2),
        .wrap_flag(wrap_flag2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: ordered queue of packed words, a halted flag and the
    // number of words delivered since reset/restart.
    logic [15:0] m_q [$];
    int          m_cnt   = 0;
    int          m_pops  = 0;
    logic        m_halted = 1'b0;
    logic        m_push, m_pop, m_restart;

    assign m_push    = in_valid && !m_halted && (m_cnt < DEPTH);
    assign m_pop     = (m_cnt != 0) && out_ready;
    assign m_restart = m_halted && restart && (m_cnt == 0);

    // Model update on each clock edge, cleared asynchronously by reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_cnt    <= 0;
            m_pops   <= 0;
            m_halted <= 1'b0;
        end else begin
            if (m_pop) void'(m_q.pop_front());
            if (m_push) m_q.push_back({in_opcode, in_param1, in_param2});
            m_cnt <= m_cnt + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
            if (m_push && (in_opcode == HALT_OP)) m_halted <= 1'b1;
            else if (m_restart) m_halted <= 1'b0;
            if (m_restart) m_pops <= 0;
            else if (m_pop) m_pops <= m_pops + 1;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready",   in_ready,   (!m_halted && m_cnt < DEPTH));
            check("out_valid",  out_valid,  (m_cnt != 0));
            check("count",      count,      m_cnt);
            check("done",       done,       (m_halted && m_cnt == 0));
            check("out_addr",   out_addr,   m_pops % 256);
            check("wrap_flag",  wrap_flag,  (m_pops >= 256));
            check("in_ready2",  in_ready2,  (!m_halted && m_cnt < DEPTH));
            check("count2",     count2,     m_cnt);
            check("out_valid2", out_valid2, (m_cnt != 0));
            check("done2",      done2,      (m_halted && m_cnt == 0));
            check("out_addr2",  out_addr2,  m_pops % 4);
            check("wrap_flag2", wrap_flag2, (m_pops >= 4));
            if (m_cnt != 0) begin
                check("out_instruction",  out_instruction,  m_q[0]);
                check("out_instruction2", out_instruction2, m_q[0]);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] op, input logic [5:0] p1, input logic [5:0] p2);
        in_valid  = 1'b1;
        in_opcode = op;
        in_param1 = p1;
        in_param2 = p2;
    endtask

    task automatic wait_accept();
        int k;
        for (k = 0; k < 64; k++) begin
            if (in_ready) begin
                cyc();
                break;
            end
            cyc();
        end
        if (k == 64) check("accept_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic push_word(input logic [3:0] op, input logic [5:0] p1, input logic [5:0] p2);
        present(op, p1, p2);
        wait_accept();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        restart  = 1'b0;
        rst      = 1'b1;
        cyc();
        rst      = 1'b0;
    endtask

    initial begin
        // Reset state while reset is held.
        #1;
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_instr", out_instruction, 32'h0000);
        check("rst_count", count, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        check("post_rst_in_ready", in_ready, 32'd1);

        // Encode: word appears the cycle after acceptance.
        out_ready = 1'b1;
        push_word(4'h3, 6'h2A, 6'h15);
        check("enc_instr", out_instruction, 32'h3A95);
        check("enc_addr", out_addr, 32'd0);
        check("enc_valid", out_valid, 32'd1);
        cyc();

        // Backpressure: four fill the buffer, fifth waits for space.
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_word(4'(i), 6'(i), 6'(i));
        check("bp_in_ready", in_ready, 32'd0);
        check("bp_count", count, 32'd4);
        check("bp_head", out_instruction, 32'h1041);
        present(4'h5, 6'h05, 6'h05);
        cyc();
        cyc();
        check("bp_held_count", count, 32'd4);
        out_ready = 1'b1;
        wait_accept();
        repeat (6) cyc();
        check("bp_final_addr", out_addr, 32'd5);

        // Halt: third word refused, done after drain, restart renumbers from 0.
        do_reset();
        out_ready = 1'b0;
        push_word(4'h1, 6'h05, 6'h0A);
        check("halt_head", out_instruction, 32'h114A);
        push_word(HALT_OP, 6'h00, 6'h01);
        check("halt_in_ready", in_ready, 32'd0);
        present(4'h2, 6'h3F, 6'h00);
        cyc();
        out_ready = 1'b1;
        restart   = 1'b1;
        cyc();
        restart   = 1'b0;
        for (int k = 0; k < 10 && !done; k++) cyc();
        check("halt_done", done, 32'd1);
        check("halt_in_ready_done", in_ready, 32'd0);
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        check("restart_in_ready", in_ready, 32'd1);
        cyc();
        in_valid = 1'b0;
        check("restart_instr", out_instruction, 32'h2FC0);
        check("restart_addr", out_addr, 32'd0);
        cyc();

        // Address wrap on both counter widths.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 261; i++) push_word(4'(i % 15), 6'(i), ~6'(i));
        cyc();
        cyc();
        check("wrap2_addr", out_addr2, 32'd1);
        check("wrap2_flag", wrap_flag2, 32'd1);
        check("wrap8_addr", out_addr, 32'd5);
        check("wrap8_flag", wrap_flag, 32'd1);

        // Simultaneous push and pop keeps occupancy and order.
        do_reset();
        out_ready = 1'b0;
        push_word(4'h4, 6'h01, 6'h02);
        push_word(4'h5, 6'h3F, 6'h3F);
        check("sim_count_before", count, 32'd2);
        present(4'h6, 6'h00, 6'h3F);
        out_ready = 1'b1;
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("sim_count_after", count, 32'd2);
        check("sim_head", out_instruction, 32'h5FFF);
        out_ready = 1'b1;
        repeat (3) cyc();

        // Reset mid-stream clears immediately and discards buffered words.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(4'h7, 6'(i), 6'h11);
        check("mid_count", count, 32'd3);
        @(negedge clk);
        #2;
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 32'd0);
        check("mid_rst_count", count, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        check("mid_in_ready", in_ready, 32'd1);
        check("mid_addr", out_addr, 32'd0);
        check("mid_valid", out_valid, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_encode.md
INSTR_ENCODE -- requirements
Module: instr_encode

Interface
REQ-001 Parameter DEPTH, 4, number of entries in the encoded-word buffer (power of 2, >=2).
REQ-002 Parameter ADDR_W, 8, width of program-address counter.
REQ-003 Parameter HALT_OP, 4'hF, opcode that terminates a program stream.
REQ-004 IE_clock  in  1  single clock; all state on rising edge.
REQ-005 IE_reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  field set on in_opcode/in_param1/in_param2 is valid.
REQ-007 in_opcode  in  4  opcode field.
REQ-008 in_param1  in  6  first parameter field.
REQ-009 in_param2  in  6  second parameter field.
REQ-010 in_ready  out  1  block accepts a field set this cycle.
REQ-011 out_valid  out  1  out_instruction/out_addr hold a valid encoded word.
REQ-012 out_ready  in  1  downstream accepts the current word.
REQ-013 out_instruction  out  16  encoded word.
REQ-014 out_addr  out  ADDR_W  program address of current word.
REQ-015 restart  in  1  single-cycle pulse; leaves HALTED state.
REQ-016 count  out  $clog2(DEPTH)+1  buffer occupancy.
REQ-017 done  out  1  halt word delivered and buffer empty.
REQ-018 wrap_flag  out  1  sticky; address counter has wrapped.

Function
REQ-019 Encoding SHALL be {in_opcode, in_param1, in_param2}: opcode bits [15:12], param1 [11:6], param2 [5:0]; no field modification.
REQ-020 Input handshake: field set accepted on a rising edge where in_valid && in_ready; encoded word written to buffer tail on that edge.
REQ-021 Output handshake: head word consumed on a rising edge where out_valid && out_ready.
REQ-022 out_valid SHALL equal (count != 0); out_instruction SHALL be the buffer head and SHALL hold stable while out_valid && !out_ready.
REQ-023 Latency: a word accepted at edge N into an empty buffer SHALL appear on out_instruction with out_valid=1 in the cycle following edge N.
REQ-024 Words SHALL leave in acceptance order (FIFO).
REQ-025 FSM states: RUN, HALTED; reset state RUN.
REQ-026 RUN: in_ready = (count < DEPTH); no same-cycle pass-through when full.
REQ-027 RUN -> HALTED on acceptance of a word whose opcode == HALT_OP; the halt word itself is buffered and emitted.
REQ-028 HALTED: in_ready = 0; buffer continues to drain.
REQ-029 done = 1 iff state HALTED and count == 0.
REQ-030 HALTED -> RUN on restart=1 only when count == 0; out_addr counter cleared to 0 on that edge, wrap_flag cleared; restart ignored otherwise and in RUN.
REQ-031 Simultaneous push and pop: count unchanged, both operations performed.
REQ-032 Push only: count+1; pop only: count-1; count never exceeds DEPTH nor goes below 0.
REQ-033 Buffer read/write pointers SHALL wrap modulo DEPTH.
REQ-034 out_addr SHALL increment by 1 on each output handshake; from 2^ADDR_W-1 it wraps to 0 and sets wrap_flag on that edge.

Reset
REQ-035 While IE_reset=1, asynchronously: state RUN, count 0, pointers 0, out_valid 0, out_instruction 16'h0000, out_addr 0, done 0, wrap_flag 0.
REQ-036 in_ready SHALL read 1 in the first cycle after IE_reset deasserts.
REQ-037 Reset asserted mid-stream SHALL discard all buffered words; no output handshake completes during reset.

Verification
REQ-038 Encode: push opcode 4'h3, p1 6'h2A, p2 6'h15 with out_ready=1 -> next cycle out_instruction 16'h3A95, out_addr 0, out_valid 1.
REQ-039 Backpressure: out_ready=0, push 5 words at DEPTH=4 -> in_ready 0 after 4th, count 4, 5th held; release out_ready -> 5 words emitted in order, addresses 0..4.
REQ-040 Halt: push 2'h1xx word then HALT_OP word then another word -> only first two accepted, in_ready 0 after halt, done 1 once both consumed; restart -> in_ready 1, next word at out_addr 0.
REQ-041 Wrap: ADDR_W=2, emit 5 words -> out_addr 0,1,2,3,0; wrap_flag 1 from the 4th consume onward.
REQ-042 Simultaneous: count=2, push and pop same edge -> count stays 2, order preserved.
REQ-043 Reset mid-operation: count=3, assert IE_reset asynchronously between edges -> out_valid 0, count 0 immediately; after release in_ready 1, out_addr 0.
